// File: rtl/skeleton_ctrl_pkg.sv
// Shared constants, state encoding and sizing helpers for the skeleton byte-stream controller.
package skeleton_ctrl_pkg;

    localparam logic [7:0] OP_CALC     = 8'hA1;
    localparam logic [7:0] OP_HEAD     = 8'hA2;
    localparam logic [7:0] ERR_OPCODE  = 8'hEE;
    localparam logic [7:0] ERR_TIMEOUT = 8'hEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_WORD,
        S_TRIG,
        S_WAIT,
        S_TX_RES,
        S_TX_HEAD,
        S_TX_ERR
    } ctrl_state_t;

    function automatic int unsigned ceil_bytes(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skeleton_byte_serializer.sv
// Loads a word plus a byte count and emits the bytes MSB first over a valid/ready handshake.
module skeleton_byte_serializer
    import skeleton_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [W-1:0]                        word,
    input  logic [$clog2(ceil_bytes(W)+1)-1:0]  n_bytes,
    input  logic                                ready,
    output logic [7:0]                          data,
    output logic                                valid,
    output logic                                last
);

    localparam int unsigned NB = ceil_bytes(W);
    localparam int unsigned SW = 8 * NB;
    localparam int unsigned CW = $clog2(NB + 1);

    logic [SW-1:0] sr;
    logic [CW-1:0] cnt;

    // The loaded word is left-aligned so the first byte to send always sits at the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= SW'(word) << (8 * (NB - 32'(n_bytes)));
            cnt <= n_bytes;
        end else if (valid && ready) begin
            sr  <= sr << 8;
            cnt <= cnt - CW'(1);
        end
    end

    assign valid = (cnt != '0);
    assign data  = sr[SW-1 -: 8];
    assign last  = valid && ready && (cnt == CW'(1));

endmodule

// File: rtl/skeleton_io_ctrl.sv
// Host byte-link command controller in front of a SKELETON_* block.
// Optional WAIT timeout (error byte 0xEF) is built only when SKELETON_CTRL_TIMEOUT_EN is defined.
module skeleton_io_ctrl
    import skeleton_ctrl_pkg::*;
#(
    parameter int unsigned BITWIDTH_DATA  = 16,
    parameter int unsigned BITWIDTH_HEAD  = 26,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK_SYS,
    input  logic                     RSTN,
    input  logic                     EN,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    output logic                     RX_READY,
    output logic [7:0]               TX_DATA,
    output logic                     TX_VALID,
    input  logic                     TX_READY,
    output logic                     SKEL_EN,
    output logic                     SKEL_TRGG_START_CALC,
    output logic [BITWIDTH_DATA-1:0] SKEL_DATA_IN,
    input  logic [BITWIDTH_DATA-1:0] SKEL_DATA_OUT,
    input  logic [BITWIDTH_HEAD-1:0] SKEL_DATA_HEAD,
    input  logic                     SKEL_DATA_VALID
);

    localparam int unsigned N_DATA = ceil_bytes(BITWIDTH_DATA);
    localparam int unsigned N_HEAD = ceil_bytes(BITWIDTH_HEAD);
    localparam int unsigned NB_MAX = max_u(N_DATA, N_HEAD);
    localparam int unsigned CW     = $clog2(NB_MAX + 1);
    localparam int unsigned SER_W  = 8 * NB_MAX;

    ctrl_state_t state, next_state;

    logic                     active;
    logic                     rx_ready;
    logic                     rx_fire;
    logic                     trig;
    logic                     timeout;
    logic                     last_rx_byte;
    logic [CW-1:0]            byte_cnt;
    logic [BITWIDTH_DATA-1:0] data_in_reg;
    logic [BITWIDTH_DATA-1:0] res_word;
    logic [BITWIDTH_HEAD-1:0] head_word;
    logic [7:0]               err_code;

    logic                     ser_load;
    logic [SER_W-1:0]         ser_word;
    logic [CW-1:0]            ser_nbytes;
    logic [7:0]               ser_data;
    logic                     ser_valid;
    logic                     ser_last;

    // EN low behaves exactly like reset, so both fold into one synchronous clear.
    assign active       = RSTN && EN;
    assign rx_fire      = RX_VALID && rx_ready;
    assign last_rx_byte = (byte_cnt == CW'(N_DATA - 1));

    always_ff @(posedge CLK_SYS) begin
        if (!active) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (rx_fire) begin
                    if (RX_DATA == OP_CALC) begin
                        next_state = S_RX_WORD;
                    end else if (RX_DATA == OP_HEAD) begin
                        next_state = S_TX_HEAD;
                    end else begin
                        next_state = S_TX_ERR;
                    end
                end
            end
            S_RX_WORD: begin
                if (rx_fire && last_rx_byte) begin
                    next_state = S_TRIG;
                end
            end
            S_TRIG: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (SKEL_DATA_VALID) begin
                    next_state = S_TX_RES;
                end else if (timeout) begin
                    next_state = S_TX_ERR;
                end
            end
            S_TX_RES, S_TX_HEAD, S_TX_ERR: begin
                if (ser_last) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // The serializer is loaded on the first cycle of each TX state, so TX_VALID rises one cycle later.
    always_comb begin
        rx_ready   = 1'b0;
        trig       = 1'b0;
        ser_load   = 1'b0;
        ser_word   = '0;
        ser_nbytes = '0;
        case (state)
            S_IDLE, S_RX_WORD: begin
                rx_ready = active;
            end
            S_TRIG: begin
                trig = active;
            end
            S_TX_RES: begin
                ser_load   = !ser_valid;
                ser_word   = SER_W'(res_word);
                ser_nbytes = CW'(N_DATA);
            end
            S_TX_HEAD: begin
                ser_load   = !ser_valid;
                ser_word   = SER_W'(head_word);
                ser_nbytes = CW'(N_HEAD);
            end
            S_TX_ERR: begin
                ser_load   = !ser_valid;
                ser_word   = SER_W'(err_code);
                ser_nbytes = CW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK_SYS) begin
        if (!active) begin
            byte_cnt    <= '0;
            data_in_reg <= '0;
            res_word    <= '0;
            head_word   <= '0;
            err_code    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= '0;
                        if (RX_DATA == OP_HEAD) begin
                            head_word <= SKEL_DATA_HEAD;
                        end else if (RX_DATA != OP_CALC) begin
                            err_code <= ERR_OPCODE;
                        end
                    end
                end
                S_RX_WORD: begin
                    if (rx_fire) begin
                        data_in_reg <= (data_in_reg << 8) | BITWIDTH_DATA'(RX_DATA);
                        byte_cnt    <= last_rx_byte ? '0 : byte_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (SKEL_DATA_VALID) begin
                        res_word <= SKEL_DATA_OUT;
                    end else if (timeout) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SKELETON_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;

    // Counts WAIT cycles; it expires on the last of TIMEOUT_CYCLES cycles without valid.
    always_ff @(posedge CLK_SYS) begin
        if (!active || state != S_WAIT) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    assign timeout = (state == S_WAIT) && !SKEL_DATA_VALID && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    skeleton_byte_serializer #(
        .W(SER_W)
    ) u_serializer (
        .clk     (CLK_SYS),
        .rst_n   (active),
        .load    (ser_load),
        .word    (ser_word),
        .n_bytes (ser_nbytes),
        .ready   (TX_READY),
        .data    (ser_data),
        .valid   (ser_valid),
        .last    (ser_last)
    );

    assign RX_READY             = rx_ready;
    assign TX_VALID             = active && ser_valid;
    assign TX_DATA              = active ? ser_data : 8'h00;
    assign SKEL_EN              = active;
    assign SKEL_TRGG_START_CALC = trig;
    assign SKEL_DATA_IN         = active ? data_in_reg : '0;

endmodule
